// File: rtl/bin_to_gray_counter_if.sv
// Purpose: control and status bundle for the binary/Gray pointer counter.
// Latency: none (wiring only); the counter registers every output it drives.
// Backpressure: none; control is sampled every clock and status is always valid.
interface bin_to_gray_counter_if #(
    parameter int unsigned W = 4
);
    logic         en;
    logic         up_dn;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic         wrap;
    logic         step_err;

    // Side that steers the counter and observes its count
    modport master (
        output en, up_dn, load, load_val,
        input  bin, gray, wrap, step_err
    );

    // The counter itself
    modport slave (
        input  en, up_dn, load, load_val,
        output bin, gray, wrap, step_err
    );
endinterface

// File: rtl/bin_to_gray_counter.sv
// Purpose: W-bit up/down binary counter with a Gray-coded copy, used as a clock-crossing pointer source.
// Latency: one clock from en/load to the updated bin/gray/wrap; all outputs registered.
// Backpressure: none; a load or step is accepted on every rising edge.
module bin_to_gray_counter #(
    parameter int unsigned W    = 4,
    parameter int unsigned INIT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    bin_to_gray_counter_if.slave cnt
);
    localparam logic [W-1:0] INIT_BIN  = W'(INIT);
    localparam logic [W-1:0] INIT_GRAY = INIT_BIN ^ (INIT_BIN >> 1);
    localparam logic [W-1:0] ONE       = W'(1);
    localparam logic [W-1:0] ALL_ONES  = '1;
    localparam logic [W-1:0] ZERO      = '0;

    logic [W-1:0] bin_q;
    logic [W-1:0] gray_q;
    logic         wrap_q;
    logic         err_q;

    logic [W-1:0] bin_next;
    logic [W-1:0] gray_next;
    logic [W-1:0] gray_diff;
    logic         wrap_next;
    logic         count_step;
    logic         multi_bit;

    // Next count: load beats counting; wrap only flags real counting steps
    always_comb begin
        bin_next   = bin_q;
        wrap_next  = 1'b0;
        count_step = 1'b0;
        if (cnt.load) begin
            bin_next = cnt.load_val;
        end else if (cnt.en) begin
            count_step = 1'b1;
            if (cnt.up_dn) begin
                bin_next  = bin_q + ONE;
                wrap_next = (bin_q == ALL_ONES);
            end else begin
                bin_next  = bin_q - ONE;
                wrap_next = (bin_q == ZERO);
            end
        end
        gray_next = bin_next ^ (bin_next >> 1);
        // x & (x-1) clears the lowest set bit; anything left means two or more bits flipped
        gray_diff = gray_q ^ gray_next;
        multi_bit = ((gray_diff & (gray_diff - ONE)) != ZERO);
    end

    // Count, Gray copy, wrap pulse and sticky step error all update on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= INIT_BIN;
            gray_q <= INIT_GRAY;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            bin_q  <= bin_next;
            gray_q <= gray_next;
            wrap_q <= wrap_next;
            if (count_step && multi_bit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign cnt.bin      = bin_q;
    assign cnt.gray     = gray_q;
    assign cnt.wrap     = wrap_q;
    assign cnt.step_err = err_q;
endmodule
